// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes the MEM-stage load/store address and routes accesses
// inside the MMIO window to a single-outstanding peripheral bus. It produces
// core_MEM's d_valid/d_ready/d_rdata, a pipeline stall, and a fault pulse for
// bus errors and timeouts. Accesses outside the window pass through untouched.
module mmio_bridge #(
   parameter logic [63:0] MMIO_BASE = 64'hFFFF_0000,
   parameter logic [63:0] MMIO_MASK = 64'hFFFF_0000,
   parameter int unsigned TIMEOUT   = 255            // 1..65535
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   input  logic [1:0]  mem_load_type,
   input  logic [1:0]  mem_store_type,
   input  logic        signed_byte,
   input  logic        signed_word,
   input  logic        flush,
   output logic        stall,
   output logic        d_valid,
   output logic        d_ready,
   output logic [63:0] d_rdata,
   output logic        bus_fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [1:0]  bus_size,
   output logic [63:0] bus_addr,
   output logic [63:0] bus_wdata,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [63:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter value seen in the last REQ cycle allowed before a forced timeout.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] rdata_q, rdata_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic        sb_q, sb_d;
   logic        sw_q, sw_d;
   logic        killed_q, killed_d;
   logic        fault_q, fault_d;
   logic [15:0] cnt_q, cnt_d;

   logic is_load, is_store, in_window, hit;

   assign is_load   = |mem_load_type;
   assign is_store  = |mem_store_type;
   assign in_window = (addr & MMIO_MASK) == MMIO_BASE;
   assign hit       = in_window && (is_load || is_store);

   // The load result is registered at completion and held until the next DONE.
   assign d_rdata = rdata_q;

   // Right-justified bus data extended to 64 bits according to access size.
   function automatic logic [63:0] extend(input logic [1:0]  size,
                                          input logic        sb,
                                          input logic        sw,
                                          input logic [63:0] raw);
      logic [63:0] res;
      res = raw;
      case (size)
         2'd1:    res = sb ? {{56{raw[7]}}, raw[7:0]}   : {56'd0, raw[7:0]};
         2'd2:    res = sw ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

   // Next-state and output decode for the IDLE/REQ/DONE bus sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      size_d    = size_q;
      we_d      = we_q;
      sb_d      = sb_q;
      sw_d      = sw_q;
      killed_d  = killed_q;
      fault_d   = fault_q;
      cnt_d     = cnt_q;
      stall     = 1'b0;
      d_valid   = 1'b0;
      d_ready   = 1'b0;
      bus_fault = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_size  = 2'd0;
      bus_addr  = 64'd0;
      bus_wdata = 64'd0;

      // Outputs are forced low while reset is held, even if a hit is decoded.
      if (reset) begin
         case (state_q)
            IDLE: begin
               d_ready = hit && is_store;
               if (hit && !flush) begin
                  stall    = 1'b1;
                  addr_d   = addr;
                  wdata_d  = wdata;
                  we_d     = is_store;
                  size_d   = is_store ? mem_store_type : mem_load_type;
                  sb_d     = signed_byte;
                  sw_d     = signed_word;
                  killed_d = 1'b0;
                  fault_d  = 1'b0;
                  cnt_d    = 16'd0;
                  state_d  = REQ;
               end
            end

            REQ: begin
               stall     = 1'b1;
               bus_req   = 1'b1;
               bus_we    = we_q;
               bus_size  = size_q;
               bus_addr  = addr_q;
               bus_wdata = wdata_q;
               d_ready   = we_q;
               cnt_d     = cnt_q + 16'd1;
               // A flushed access still runs to completion; only its results die.
               if (flush) killed_d = 1'b1;
               if (bus_ack) begin
                  rdata_d = extend(size_q, sb_q, sw_q, bus_rdata);
                  fault_d = bus_err;
                  state_d = DONE;
               end else if (cnt_q == CNT_LAST) begin
                  rdata_d = '1;
                  fault_d = 1'b1;
                  state_d = DONE;
               end
            end

            DONE: begin
               // Pipeline is still frozen, so the live decode is the same access.
               d_ready   = hit && is_store;
               d_valid   = !we_q && !killed_q;
               bus_fault = fault_q && !killed_q;
               state_d   = IDLE;
            end

            default: state_d = IDLE;
         endcase
      end
   end

   // State and latched-access registers.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: the datapath latches are reset too, so d_rdata and the bus
      // fields read as zero out of reset rather than X.
      if (!reset) begin
         state_q  <= IDLE;
         addr_q   <= 64'd0;
         wdata_q  <= 64'd0;
         rdata_q  <= 64'd0;
         size_q   <= 2'd0;
         we_q     <= 1'b0;
         sb_q     <= 1'b0;
         sw_q     <= 1'b0;
         killed_q <= 1'b0;
         fault_q  <= 1'b0;
         cnt_q    <= 16'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of its _d input.
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         size_q   <= size_d;
         we_q     <= we_d;
         sb_q     <= sb_d;
         sw_q     <= sw_d;
         killed_q <= killed_d;
         fault_q  <= fault_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: stimulus pushes expected load/fault
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_mmio_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] addr = '0, wdata = '0, bus_rdata = '0;
   logic [1:0]  mem_load_type = '0, mem_store_type = '0;
   logic        signed_byte = 1'b0, signed_word = 1'b0, flush = 1'b0;
   logic        bus_ack = 1'b0, bus_err = 1'b0;
   logic        stall, d_valid, d_ready, bus_fault, bus_req, bus_we;
   logic [1:0]  bus_size;
   logic [63:0] d_rdata, bus_addr, bus_wdata;

   always #5 clock = ~clock;

   mmio_bridge #(.TIMEOUT(4)) dut (
      .clock(clock), .reset(reset), .addr(addr), .wdata(wdata),
      .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
      .signed_byte(signed_byte), .signed_word(signed_word), .flush(flush),
      .stall(stall), .d_valid(d_valid), .d_ready(d_ready), .d_rdata(d_rdata),
      .bus_fault(bus_fault), .bus_req(bus_req), .bus_we(bus_we),
      .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic        valid;
      logic [63:0] rdata;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   logic        cap_we;
   logic [1:0]  cap_size;
   logic [63:0] cap_addr, cap_wdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic v, input logic [63:0] r, input logic f);
      exp_t e;
      e.valid = v;
      e.rdata = r;
      e.fault = f;
      return e;
   endfunction

   // Monitor: every DUT completion report is matched against the scoreboard.
   always @(negedge clock) begin
      if (reset && (d_valid || bus_fault)) begin
         check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("mon_d_valid", 64'(d_valid), 64'(e.valid));
            check("mon_bus_fault", 64'(bus_fault), 64'(e.fault));
            if (e.valid) check("mon_d_rdata", d_rdata, e.rdata);
         end
      end
   end

   // Drives one access and acts as the bus peripheral; counts per-cycle flags.
   task automatic run_access(input string tag, input logic [63:0] a, input logic [63:0] wd,
                             input logic [1:0] lt, input logic [1:0] st,
                             input logic sb, input logic sw, input int ack_at,
                             input logic [63:0] rd, input logic err, input int flush_at,
                             input int max_cyc, input logic expect_done,
                             output int n_stall, output int n_req, output int n_dready,
                             output int n_dvalid, output int n_fault);
      logic req_seen, done;
      addr = a; wdata = wd; mem_load_type = lt; mem_store_type = st;
      signed_byte = sb; signed_word = sw;
      n_stall = 0; n_req = 0; n_dready = 0; n_dvalid = 0; n_fault = 0;
      req_seen = 1'b0; done = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clock);
         if (bus_req) begin
            n_req++;
            req_seen = 1'b1;
            if (n_req == 1) begin
               cap_we = bus_we; cap_size = bus_size;
               cap_addr = bus_addr; cap_wdata = bus_wdata;
            end
            bus_ack   = (n_req == ack_at);
            bus_err   = bus_ack && err;
            bus_rdata = bus_ack ? rd : 64'd0;
            flush     = (n_req == flush_at);
         end
         n_stall  += int'(stall);
         n_dready += int'(d_ready);
         n_dvalid += int'(d_valid);
         n_fault  += int'(bus_fault);
         done = req_seen && !bus_req;
         @(posedge clock);
         #1;
         bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0; bus_rdata = 64'd0;
         if (done) break;
      end
      check({tag, "_done"}, 64'(done), 64'(expect_done));
      mem_load_type = 2'd0; mem_store_type = 2'd0;
      signed_byte = 1'b0; signed_word = 1'b0;
   endtask

   initial begin
      int ns, nr, nd, nv, nf;

      // Hit decoded while reset is held: everything must stay low.
      addr = 64'hFFFF_0010; mem_load_type = 2'd1;
      #12;
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_bus_req", 64'(bus_req), 64'd0);
      check("rst_d_ready", 64'(d_ready), 64'd0);
      check("rst_d_valid", 64'(d_valid), 64'd0);
      check("rst_d_rdata", d_rdata, 64'd0);
      check("rst_bus_fault", 64'(bus_fault), 64'd0);
      mem_load_type = 2'd0;
      @(posedge clock); #1; reset = 1'b1;
      @(posedge clock); #1;

      // Signed byte load, ack on third REQ cycle.
      exp_q.push_back(mk(1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0));
      run_access("sbyte", 64'hFFFF_0010, 64'd0, 2'd1, 2'd0, 1'b1, 1'b0, 3, 64'h80, 1'b0, 0, 20, 1'b1,
                 ns, nr, nd, nv, nf);
      check("sbyte_stall", 64'(ns), 64'd4);
      check("sbyte_req", 64'(nr), 64'd3);
      check("sbyte_dvalid", 64'(nv), 64'd1);
      check("sbyte_bus_addr", cap_addr, 64'hFFFF_0010);
      check("sbyte_bus_we", 64'(cap_we), 64'd0);

      // Same with zero extension.
      exp_q.push_back(mk(1'b1, 64'h80, 1'b0));
      run_access("ubyte", 64'hFFFF_0010, 64'd0, 2'd1, 2'd0, 1'b0, 1'b0, 3, 64'h80, 1'b0, 0, 20, 1'b1,
                 ns, nr, nd, nv, nf);
      check("ubyte_stall", 64'(ns), 64'd4);

      // Dword store, immediate ack.
      run_access("store", 64'hFFFF_0008, 64'h1122_3344_5566_7788, 2'd0, 2'd3, 1'b0, 1'b0, 1,
                 64'd0, 1'b0, 0, 20, 1'b1, ns, nr, nd, nv, nf);
      check("store_stall", 64'(ns), 64'd2);
      check("store_req", 64'(nr), 64'd1);
      check("store_dready", 64'(nd), 64'd3);
      check("store_dvalid", 64'(nv), 64'd0);
      check("store_bus_we", 64'(cap_we), 64'd1);
      check("store_bus_size", 64'(cap_size), 64'd3);
      check("store_bus_wdata", cap_wdata, 64'h1122_3344_5566_7788);

      // Non-MMIO load: bridge stays silent.
      run_access("nonmmio", 64'h0000_0040, 64'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1, 64'd0, 1'b0, 0, 4, 1'b0,
                 ns, nr, nd, nv, nf);
      check("nonmmio_any", 64'(ns + nr + nd + nv), 64'd0);

      // Word load, never acked: timeout after 4 REQ cycles.
      exp_q.push_back(mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
      run_access("tmo", 64'hFFFF_0020, 64'd0, 2'd2, 2'd0, 1'b0, 1'b1, 0, 64'd0, 1'b0, 0, 20, 1'b1,
                 ns, nr, nd, nv, nf);
      check("tmo_req", 64'(nr), 64'd4);
      check("tmo_stall", 64'(ns), 64'd5);
      check("tmo_fault", 64'(nf), 64'd1);
      // Late ack in IDLE is ignored.
      bus_ack = 1'b1; bus_rdata = 64'h1234;
      @(negedge clock);
      check("late_ack_req", 64'(bus_req), 64'd0);
      check("late_ack_stall", 64'(stall), 64'd0);
      @(posedge clock); #1; bus_ack = 1'b0; bus_rdata = 64'd0;
      @(negedge clock);
      check("late_ack_dvalid", 64'(d_valid), 64'd0);
      @(posedge clock); #1;

      // Flush in 2nd REQ cycle, ack (with error) two cycles later: nothing reported.
      run_access("killed", 64'hFFFF_0018, 64'd0, 2'd3, 2'd0, 1'b0, 1'b0, 4, 64'hABCD, 1'b1, 2, 20,
                 1'b1, ns, nr, nd, nv, nf);
      check("killed_req", 64'(nr), 64'd4);
      check("killed_dvalid", 64'(nv), 64'd0);
      check("killed_fault", 64'(nf), 64'd0);

      // Signed word load.
      exp_q.push_back(mk(1'b1, 64'hFFFF_FFFF_8000_1234, 1'b0));
      run_access("sword", 64'hFFFF_0024, 64'd0, 2'd2, 2'd0, 1'b0, 1'b1, 2, 64'hDEAD_BEEF_8000_1234,
                 1'b0, 0, 20, 1'b1, ns, nr, nd, nv, nf);
      check("sword_stall", 64'(ns), 64'd3);

      // Bus error on an unsigned byte load: data still extended, fault pulses.
      exp_q.push_back(mk(1'b1, 64'hFF, 1'b1));
      run_access("berr", 64'hFFFF_0001, 64'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1, 64'h1FF, 1'b1, 0, 20, 1'b1,
                 ns, nr, nd, nv, nf);
      check("berr_fault", 64'(nf), 64'd1);

      // Hit with flush in IDLE: no issue.
      addr = 64'hFFFF_0040; mem_load_type = 2'd3; flush = 1'b1;
      @(negedge clock);
      check("idle_flush_stall", 64'(stall), 64'd0);
      @(posedge clock); #1; flush = 1'b0; mem_load_type = 2'd0;
      @(negedge clock);
      check("idle_flush_req", 64'(bus_req), 64'd0);
      @(posedge clock); #1;

      // Reset in REQ drops bus_req and stall at once.
      addr = 64'hFFFF_0030; mem_load_type = 2'd3;
      @(posedge clock); #1;
      @(negedge clock);
      check("rmid_req_before", 64'(bus_req), 64'd1);
      reset = 1'b0;
      #1;
      check("rmid_req", 64'(bus_req), 64'd0);
      check("rmid_stall", 64'(stall), 64'd0);
      mem_load_type = 2'd0;
      @(posedge clock); #1; reset = 1'b1;
      @(posedge clock); #1;
      exp_q.push_back(mk(1'b1, 64'h55, 1'b0));
      run_access("after_rst", 64'hFFFF_0030, 64'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1, 64'h55, 1'b0, 0, 20,
                 1'b1, ns, nr, nd, nv, nf);
      check("after_rst_stall", 64'(ns), 64'd2);

      repeat (3) @(posedge clock);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits beside core_MEM and feeds it: decodes the EX→MEM load/store address and routes accesses in the MMIO window to an external peripheral bus.
- Produces core_MEM's d_valid / d_ready / d_rdata inputs and a pipeline stall.
- Accesses outside the window pass straight through to data_mem untouched.
- One outstanding bus transaction at a time, with a timeout and a fault report.

Parameters:
- MMIO_BASE, 64'hFFFF_0000, base of MMIO window; an access is MMIO when (addr & MMIO_MASK) == MMIO_BASE.
- MMIO_MASK, 64'hFFFF_0000, window decode mask.
- TIMEOUT, 255, max cycles in REQ before forced completion; valid range 1..65535.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- addr  in  64  EX_regs.out, effective address.
- wdata  in  64  EX_regs.B_data, store data, right-justified.
- mem_load_type  in  2  0 none, 1 byte, 2 word, 3 dword.
- mem_store_type  in  2  0 none, 1 byte, 2 word, 3 dword.
- signed_byte  in  1  sign-extend byte loads.
- signed_word  in  1  sign-extend word loads.
- flush  in  1  kill the access currently at MEM.
- stall  out  1  freeze IF..MEM pipeline registers.
- d_valid  out  1  MMIO load result on d_rdata this cycle.
- d_ready  out  1  current MEM access is an MMIO store (suppresses data_mem write).
- d_rdata  out  64  extended load result.
- bus_fault  out  1  one-cycle pulse: bus error or timeout.
- bus_req  out  1  request, held until bus_ack.
- bus_we  out  1  1 store, 0 load.
- bus_size  out  2  copy of load/store type.
- bus_addr  out  64  latched address.
- bus_wdata  out  64  latched store data.
- bus_ack  in  1  completes the request this cycle.
- bus_err  in  1  qualifies bus_ack; access failed.
- bus_rdata  in  64  right-justified read data, valid with bus_ack.

Behaviour:
- hit = window decode of addr && (|mem_load_type || |mem_store_type). Store type wins if both are nonzero (illegal; no assertion).
- State machine: IDLE, REQ, DONE. Reset → IDLE.
- All outputs 0 in reset; the killed flag and timeout counter are cleared.

IDLE:
- hit && !flush → stall=1 combinationally. Latch addr, wdata, size, we, signed_byte, signed_word. Clear the counter. Next state REQ.
- hit && flush → no issue, stall=0, stay in IDLE.
- Non-hit → all outputs 0.

REQ:
- bus_req=1, stall=1, bus_* driven from latches; the counter increments each cycle.
- bus_ack → DONE. If the ack arrives in the first REQ cycle, this is the minimum case: 2 stall cycles total.
- Counter reaching TIMEOUT without ack → DONE as a fault, d_rdata = all ones. A late bus_ack arriving in IDLE is ignored.
- flush while in REQ sets killed. The bus transaction still completes; it is never aborted.

DONE (exactly one cycle):
- stall=0, bus_req=0, next state IDLE.
- Load and !killed → d_valid=1.
- d_rdata extension, by latched size:
  - byte: bus_rdata[7:0], sign- or zero-extended per signed_byte.
  - word: bus_rdata[31:0], sign- or zero-extended per signed_word.
  - dword: raw bus_rdata.
- bus_err or timeout → bus_fault=1. Suppressed if killed.

d_rdata capture and hold:
- d_rdata is captured at bus_ack (or timeout) into a register.
- It is held until the next DONE and is observed only when d_valid=1.

d_ready:
- 1 whenever the access at MEM is an MMIO store: in IDLE on hit-store, throughout REQ, and in DONE.
- In DONE the decode reflects the not-yet-advanced instruction.

General rules:
- No new decode is taken in REQ or DONE.
- Back-to-back MMIO accesses: DONE → IDLE → new REQ. One bubble cycle, no overlap.
- Reset mid-REQ: bus_req drops immediately (async). No fault pulse. Peripherals are expected to be reset together with the core.

Test Plan:
- Signed byte load at 0xFFFF_0010, bus_rdata=0x80, ack on the 3rd REQ cycle → stall high 4 cycles; DONE: d_valid=1, d_rdata=0xFFFF_FFFF_FFFF_FF80. Repeat with signed_byte=0 → 0x80.
- Dword store 0x1122334455667788 to 0xFFFF_0008, immediate ack → bus_we=1, bus_size=3, bus_wdata matches; d_ready high all 3 cycles; d_valid never asserted.
- Load at 0x0000_0040 (non-MMIO) → stall, d_valid, d_ready, bus_req all 0 every cycle.
- MMIO word load, bus never acks, TIMEOUT=4 → 4 REQ cycles, then DONE: d_rdata=all ones, bus_fault one-cycle pulse, then IDLE.
- flush in 2nd REQ cycle of a load, ack 2 cycles later → bus_req held until ack, then DONE with d_valid=0, bus_fault=0 even if bus_err=1.
- reset driven to 0 in REQ → bus_req, stall 0 same cycle. After release, the same MMIO load issues cleanly from IDLE.
